div_2: RTL and testbench



---
 rtl/div_2_pkg.sv | 10 +
 rtl/div_2.sv | 49 ++++
 tb/tb_div_2.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/div_2_pkg.sv
// Shared helper for the divide-by-two clock generator: edge classification
// of the toggle state, used to build the registered rise strobe.
package div_2_pkg;

  // True when the state bit goes from low to high across one clk edge.
  function automatic logic is_rise(input logic old_level, input logic new_level);
    return (~old_level) & new_level;
  endfunction

endpackage

// File: rtl/div_2.sv
// Divide-by-two clock generator: one toggle flop drives o_clk directly,
// a second flop produces a one-cycle strobe on each low-to-high transition,
// and an inverter provides the complementary clock.
module div_2
  import div_2_pkg::*;
#(
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_clk,
  output logic o_clk_n,
  output logic o_rise
);

  logic q_reg;
  logic q_next;
  logic rise_reg;
  logic rise_next;

  // Next-state values: the state always toggles, the strobe flags a 0->1 step.
  always_comb begin
    q_next    = ~q_reg;
    rise_next = is_rise(q_reg, q_next);
  end

  // Toggle flop; reset loads INIT_LEVEL without waiting for a clk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= INIT_LEVEL;
    end else begin
      q_reg <= q_next;
    end
  end

  // Rise strobe flop; held low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_reg <= 1'b0;
    end else begin
      rise_reg <= rise_next;
    end
  end

  assign o_clk   = q_reg;
  assign o_clk_n = ~q_reg;
  assign o_rise  = rise_reg;

endmodule

// File: tb/tb_div_2.sv
// Bench for div_2: two instances (INIT_LEVEL 0 and 1) share clk and reset.
// Expected outputs come from the number of clk edges seen since release.
`timescale 1ns/1ps
module tb_div_2;

  logic clk;
  logic rst_n;
  logic clk0, clk0_n, rise0;
  logic clk1, clk1_n, rise1;

  int vectors;
  int miscompares;
  int edges_since_release;
  int o_clk_rises;
  bit meas;
  longint last_t;
  longint min_half;
  longint max_half;

  div_2 #(.INIT_LEVEL(1'b0)) dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_clk  (clk0),
    .o_clk_n(clk0_n),
    .o_rise (rise0)
  );

  div_2 #(.INIT_LEVEL(1'b1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_clk  (clk1),
    .o_clk_n(clk1_n),
    .o_rise (rise1)
  );

  // 20 ns period, rising edges at 10, 30, 50, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference: count clk edges after release; reset clears the count at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges_since_release <= 0;
    else        edges_since_release <= edges_since_release + 1;
  end

  // Rising edges of the INIT_LEVEL=0 divided clock.
  always @(posedge clk0) o_clk_rises <= o_clk_rises + 1;

  // Duration of every high and low phase while measuring.
  always @(clk0) begin
    if (meas) begin
      if (last_t >= 0) begin
        if ($time - last_t < min_half) min_half = $time - last_t;
        if ($time - last_t > max_half) max_half = $time - last_t;
      end
      last_t = $time;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Compare every output of both instances against the edge-count model.
  task automatic check_all(input string phase);
    int  n;
    logic e0, e1, r0, r1;
    n  = edges_since_release;
    e0 = (n % 2 == 1);
    e1 = (n % 2 == 0);
    r0 = (n % 2 == 1);
    r1 = (n >= 2) && (n % 2 == 0);
    check({phase, " clk0"},   {31'd0, clk0},   {31'd0, e0});
    check({phase, " clk0_n"}, {31'd0, clk0_n}, {31'd0, ~e0});
    check({phase, " rise0"},  {31'd0, rise0},  {31'd0, r0});
    check({phase, " clk1"},   {31'd0, clk1},   {31'd0, e1});
    check({phase, " clk1_n"}, {31'd0, clk1_n}, {31'd0, ~e1});
    check({phase, " rise1"},  {31'd0, rise1},  {31'd0, r1});
  endtask

  // Release reset a few ns after a falling clk edge, well clear of any rising edge.
  task automatic release_reset();
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int run_len;
    int hold_len;
    vectors     = 0;
    miscompares = 0;
    o_clk_rises = 0;
    meas        = 1'b0;
    last_t      = -1;
    min_half    = 64'd1000000;
    max_half    = 0;
    rst_n       = 1'b0;

    // Reset hold across several clk edges.
    repeat (5) begin
      @(negedge clk);
      check_all("reset_hold");
    end
    $display("reset hold: 5 cycles sampled");

    // Random run lengths, each ended by an asynchronous reset mid-cycle.
    for (int seg = 0; seg < 8; seg++) begin
      release_reset();
      run_len = $urandom_range(3, 20);
      for (int c = 0; c < run_len; c++) begin
        @(negedge clk);
        check_all("run");
      end
      // Drop reset between edges while clk0 is high (odd edge count).
      if (edges_since_release % 2 == 0) @(posedge clk);
      #($urandom_range(2, 7));
      rst_n = 1'b0;
      #1;
      check("async_rst clk0", {31'd0, clk0}, 32'd0);
      check("async_rst rise0", {31'd0, rise0}, 32'd0);
      check("async_rst clk1", {31'd0, clk1}, 32'd1);
      hold_len = $urandom_range(1, 4);
      for (int c = 0; c < hold_len; c++) begin
        @(negedge clk);
        check_all("held");
      end
      $display("segment %0d: ran %0d cycles, reset held %0d cycles", seg, run_len, hold_len);
    end

    // Long run: 1000 clk edges after release give 500 clk0 rises, 20 ns phases.
    @(negedge clk);
    o_clk_rises = 0;
    meas        = 1'b1;
    release_reset();
    repeat (1000) @(posedge clk);
    #1;
    meas = 1'b0;
    check("long_run rises", o_clk_rises, 32'd500);
    check("long_run min_half_ns", min_half[31:0], 32'd20);
    check("long_run max_half_ns", max_half[31:0], 32'd20);
    @(negedge clk);
    check_all("long_run end");
    $display("long run: %0d o_clk rises, half-period %0d..%0d ns", o_clk_rises, min_half, max_half);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
